// File: rtl/pl_scr_pkg.sv
// Shared types, frame-geometry constants and payload-length helper for the PL scrambler controller.
// Pilot-block accounting is only used by builds with PLSCR_PILOT_EN defined.
package pl_scr_pkg;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  localparam int HDR_LEN         = 90;
  localparam int SLOT_LEN        = 90;
  localparam int PILOT_LEN       = 36;
  localparam int SLOTS_PER_PILOT = 16;
  localparam int MAX_CODE_N      = 262142;

  // One pilot block after every 16 slots, only when another slot follows.
  function automatic logic [15:0] payload_len(input logic [8:0] slots, input logic pilots);
    logic [15:0] p;
    p = (pilots && slots != 9'd0) ? 16'((slots - 9'd1) / 9'(SLOTS_PER_PILOT)) : 16'd0;
    return 16'(slots) * 16'(SLOT_LEN) + p * 16'(PILOT_LEN);
  endfunction

endpackage

// File: rtl/pl_scrambler_ctrl_rotator.sv
// QPSK rotation of an I/Q symbol by R quarter-turns; negation saturates so that
// the most negative code maps to the most positive one.
module pl_qpsk_rotator #(
  parameter int W = 16
) (
  input  logic [1:0]   r,
  input  logic [W-1:0] in_i,
  input  logic [W-1:0] in_q,
  output logic [W-1:0] out_i,
  output logic [W-1:0] out_q
);

  function automatic logic [W-1:0] sat_neg(input logic [W-1:0] x);
    return (x == {1'b1, {(W-1){1'b0}}}) ? {1'b0, {(W-1){1'b1}}} : (~x) + W'(1);
  endfunction

  always_comb begin
    out_i = in_i;
    out_q = in_q;
    unique case (r)
      2'd1: begin out_i = sat_neg(in_q); out_q = in_i;          end
      2'd2: begin out_i = sat_neg(in_i); out_q = sat_neg(in_q); end
      2'd3: begin out_i = in_q;          out_q = sat_neg(in_i); end
      default: ;
    endcase
  end

endmodule

// File: rtl/pl_scrambler_ctrl.sv
// PLFRAME scrambling sequencer: seeds the Gold-code generator per frame, passes the header
// and QPSK-rotates payload symbols. Build macro: PLSCR_PILOT_EN (pilot blocks in payload length).
module pl_scrambler_ctrl
  import pl_scr_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [17:0]  cfg_code_n,
  input  logic [8:0]   cfg_slots,
  input  logic         cfg_pilots,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         s_sof,
  input  logic [W-1:0] s_i,
  input  logic [W-1:0] s_q,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_sof,
  output logic         m_eof,
  output logic [W-1:0] m_i,
  output logic [W-1:0] m_q,
  output logic         gen_reset,
  output logic         gen_step,
  input  logic [1:0]   gen_r,
  output logic         busy,
  output logic         err_sof
);

  state_t       state_q, state_d;
  logic [17:0]  seed_cnt_q, seed_cnt_d;
  logic [6:0]   hdr_cnt_q, hdr_cnt_d;
  logic [15:0]  len_q, len_d, rem_q, rem_d, len_cfg;
  logic         m_valid_q, m_valid_d, m_sof_q, m_sof_d, m_eof_q, m_eof_d, err_q, err_d;
  logic [W-1:0] m_i_q, m_i_d, m_q_q, m_q_d, rot_i, rot_q;
  logic         seeding, accept, pay_step;

  pl_qpsk_rotator #(.W(W)) u_rot (
    .r(gen_r), .in_i(s_i), .in_q(s_q), .out_i(rot_i), .out_q(rot_q)
  );

`ifdef PLSCR_PILOT_EN
  assign len_cfg = payload_len(cfg_slots, cfg_pilots);
`else
  logic unused_pilots;
  assign unused_pilots = cfg_pilots;
  assign len_cfg = payload_len(cfg_slots, 1'b0);
`endif

  assign seeding = (seed_cnt_q != 18'd0);
  // Payload waits for seeding so every payload R comes from a fully advanced generator.
  assign s_ready = !reset && (!m_valid_q || m_ready) && !(state_q == PAYLOAD && seeding);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d    = state_q;
    seed_cnt_d = seeding ? seed_cnt_q - 18'd1 : seed_cnt_q;
    hdr_cnt_d  = hdr_cnt_q;
    len_d      = len_q;
    rem_d      = rem_q;
    m_valid_d  = m_valid_q && !m_ready;
    m_sof_d    = m_sof_q;
    m_eof_d    = m_eof_q;
    m_i_d      = m_i_q;
    m_q_d      = m_q_q;
    err_d      = 1'b0;
    gen_reset  = 1'b0;
    pay_step   = 1'b0;
    if (accept) begin
      if (s_sof) begin
        // A sof always starts a fresh frame; mid-frame it also aborts the old one.
        err_d      = (state_q != IDLE);
        gen_reset  = 1'b1;
        seed_cnt_d = (cfg_code_n > 18'(MAX_CODE_N)) ? 18'(MAX_CODE_N) : cfg_code_n;
        len_d      = len_cfg;
        hdr_cnt_d  = 7'd1;
        state_d    = HEADER;
        m_valid_d  = 1'b1;
        m_sof_d    = 1'b1;
        m_eof_d    = 1'b0;
        m_i_d      = s_i;
        m_q_d      = s_q;
      end else begin
        unique case (state_q)
          IDLE: err_d = 1'b1;
          HEADER: begin
            m_valid_d = 1'b1;
            m_sof_d   = 1'b0;
            m_eof_d   = 1'b0;
            m_i_d     = s_i;
            m_q_d     = s_q;
            hdr_cnt_d = hdr_cnt_q + 7'd1;
            if (hdr_cnt_q == 7'(HDR_LEN - 1)) begin
              if (len_q == 16'd0) begin
                m_eof_d = 1'b1;
                state_d = IDLE;
              end else begin
                rem_d   = len_q;
                state_d = PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            pay_step  = 1'b1;
            m_valid_d = 1'b1;
            m_sof_d   = 1'b0;
            m_eof_d   = (rem_q == 16'd1);
            m_i_d     = rot_i;
            m_q_d     = rot_q;
            rem_d     = rem_q - 16'd1;
            if (rem_q == 16'd1) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      seed_cnt_q <= '0;
      hdr_cnt_q  <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      m_valid_q  <= 1'b0;
      m_sof_q    <= 1'b0;
      m_eof_q    <= 1'b0;
      m_i_q      <= '0;
      m_q_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_cnt_q <= seed_cnt_d;
      hdr_cnt_q  <= hdr_cnt_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      m_valid_q  <= m_valid_d;
      m_sof_q    <= m_sof_d;
      m_eof_q    <= m_eof_d;
      m_i_q      <= m_i_d;
      m_q_q      <= m_q_d;
      err_q      <= err_d;
    end
  end

  assign gen_step = !reset && !gen_reset && (seeding || pay_step);
  assign busy     = (state_q != IDLE) || seeding;
  assign m_valid  = m_valid_q;
  assign m_sof    = m_sof_q;
  assign m_eof    = m_eof_q;
  assign m_i      = m_i_q;
  assign m_q      = m_q_q;
  assign err_sof  = err_q;

endmodule

// File: tb/tb_pl_scrambler_ctrl.sv
// Bench for pl_scrambler_ctrl: table vectors for rotation/saturation, hand sequences for
// seeding, abort and reset, and random frames against a frame-level reference model.
module tb_pl_scrambler_ctrl;
  localparam int W = 16;
`ifdef PLSCR_PILOT_EN
  localparam bit PIL_EN = 1'b1;
`else
  localparam bit PIL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [17:0] cfg_code_n;
  logic [8:0] cfg_slots;
  logic cfg_pilots;
  logic s_valid, s_ready, s_sof;
  logic [W-1:0] s_i, s_q;
  logic m_valid, m_ready, m_sof, m_eof;
  logic [W-1:0] m_i, m_q;
  logic gen_reset, gen_step;
  logic [1:0] gen_r;
  logic busy, err_sof;

  always #5 clk = ~clk;

  pl_scrambler_ctrl #(.W(W)) dut (
    .clk(clk), .reset(reset), .cfg_code_n(cfg_code_n), .cfg_slots(cfg_slots),
    .cfg_pilots(cfg_pilots), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .s_i(s_i), .s_q(s_q), .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof),
    .m_eof(m_eof), .m_i(m_i), .m_q(m_q), .gen_reset(gen_reset), .gen_step(gen_step),
    .gen_r(gen_r), .busy(busy), .err_sof(err_sof)
  );

  typedef struct { int i; int q; bit sof; bit eof; } sym_t;
  typedef struct { int n; int s; logic [1:0] r; int i; int q; int ei; int eq; } vec_t;

  sym_t exp_q[$];
  sym_t got_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, k_gen = 0;
  int n_step = 0, n_rst = 0, n_err = 0, rst_cyc = 0, step_first = -1, step_last = -1;
  int acc_cyc = 0, pay0_cyc = 0;
  int rdy_pct = 100, vld_pct = 100;
  bit force_en = 1'b0;
  logic [1:0] force_r = 2'd0;

  // Generator stand-in: R is a hash of how many steps since the last gen_reset.
  function automatic logic [1:0] gold(input int k);
    logic [31:0] h;
    h = 32'(k) * 32'h9E3779B1;
    h = h ^ (h >> 16);
    return h[31:30];
  endfunction
  assign gen_r = force_en ? force_r : gold(k_gen);

  function automatic int sat(input int x);
    int mx;
    mx = (1 << (W - 1)) - 1;
    return (x > mx) ? mx : ((x < -mx - 1) ? -mx - 1 : x);
  endfunction

  // Multiply by j r times in full precision, then clip to the sample range.
  function automatic sym_t rot(input int i, input int q, input logic [1:0] r);
    int a, b, t;
    sym_t s;
    a = i; b = q;
    for (int k = 0; k < int'(r); k++) begin t = a; a = -b; b = t; end
    s.i = sat(a); s.q = sat(b); s.sof = 1'b0; s.eof = 1'b0;
    return s;
  endfunction

  function automatic int exp_len(input int s, input bit pil);
    return 90 * s + ((PIL_EN && pil && s > 0) ? 36 * ((s - 1) / 16) : 0);
  endfunction

  function automatic longint pack(input sym_t s);
    return {30'd0, s.sof, s.eof, 16'(s.i), 16'(s.q)};
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic die(input string what, input int waited);
    n_chk++; n_fail++;
    $display("FAIL timeout_%s: waited %0d cycles, required fewer than 3000", what, waited);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  // One clock: sample at the falling edge, then advance the generator model after the rise.
  task automatic step(output bit acc);
    bit rs, st;
    m_ready = ($urandom_range(99) < rdy_pct);
    @(negedge clk);
    acc = s_valid && s_ready;
    if (acc) acc_cyc = cyc;
    if (m_valid && m_ready)
      got_q.push_back('{int'($signed(m_i)), int'($signed(m_q)), m_sof, m_eof});
    rs = gen_reset; st = gen_step;
    chk("gen_reset_step_exclusive", longint'(rs && st), 0);
    if (rs) begin n_rst++; rst_cyc = cyc; end
    if (st) begin n_step++; if (step_first < 0) step_first = cyc; step_last = cyc; end
    if (err_sof) n_err++;
    @(posedge clk); #1;
    if (rs) k_gen = 0;
    else if (st) k_gen++;
    cyc++;
  endtask

  task automatic send(input int i, input int q, input bit sof);
    bit a;
    int g;
    g = 0;
    s_i = W'(i); s_q = W'(q); s_sof = sof;
    do begin
      s_valid = ($urandom_range(99) < vld_pct);
      step(a);
      g++;
      if (g > 3000) die("send", g);
    end while (!a);
    s_valid = 1'b0;
  endtask

  // Sends a frame (or its first stop_at symbols) and queues the expected output stream.
  task automatic frame(input int n, input int s, input bit pil, input int stop_at,
                       input bit fixed, input int fi, input int fq);
    int total, i, q;
    sym_t e;
    total = 90 + exp_len(s, pil);
    cfg_code_n = 18'(n); cfg_slots = 9'(s); cfg_pilots = pil;
    for (int idx = 0; idx < total && (stop_at < 0 || idx < stop_at); idx++) begin
      if (fixed) begin i = fi; q = fq; end
      else begin
        i = ($urandom_range(15) == 0) ? -32768 : int'($signed(W'($urandom)));
        q = ($urandom_range(15) == 0) ? -32768 : int'($signed(W'($urandom)));
      end
      send(i, q, idx == 0);
      if (idx == 0) begin
        cfg_code_n = 18'($urandom); cfg_slots = 9'($urandom); cfg_pilots = 1'($urandom);
      end
      if (idx == 90) pay0_cyc = acc_cyc;
      if (idx < 90) begin e.i = i; e.q = q; end
      else e = rot(i, q, force_en ? force_r : gold(n + idx - 90));
      e.sof = (idx == 0);
      e.eof = (idx == total - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    bit a;
    int g;
    g = 0;
    s_valid = 1'b0;
    while (got_q.size() < exp_q.size() || m_valid) begin
      step(a);
      g++;
      if (g > 3000) die("drain", g);
    end
    repeat (3) step(a);
  endtask

  task automatic compare(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
      chk($sformatf("%s_sym%0d", name, j), pack(got_q[j]), pack(exp_q[j]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_sof_eof"}, {m_sof, m_eof}, 0);
    chk({tag, "_m_iq"}, {m_i, m_q}, 0);
    chk({tag, "_gen"}, {gen_reset, gen_step}, 0);
    chk({tag, "_busy_err"}, {busy, err_sof}, 0);
  endtask

  initial begin
    #800000;
    die("global", cyc);
  end

  initial begin
    vec_t vecs[6];
    bit a;
    int s0, r0, e0, mism, eofpos, junk;

    vecs[0] = '{0, 1, 2'd1,    100,    -50,     50,    100};
    vecs[1] = '{0, 1, 2'd2, -32768,      0,  32767,      0};
    vecs[2] = '{0, 1, 2'd3,      5, -32768, -32768,     -5};
    vecs[3] = '{0, 1, 2'd1, -32768,      7,     -7, -32768};
    vecs[4] = '{0, 1, 2'd0, -32768, -32768, -32768, -32768};
    vecs[5] = '{3, 1, 2'd2,   1234, -32768,  -1234,  32767};

    reset = 1'b1; s_valid = 1'b1; s_sof = 1'b1; s_i = '0; s_q = '0; m_ready = 1'b1;
    cfg_code_n = '0; cfg_slots = '0; cfg_pilots = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0; s_valid = 1'b0; s_sof = 1'b0;

    // Forced-R vectors: header untouched, every payload symbol rotated to the table value.
    force_en = 1'b1;
    foreach (vecs[v]) begin
      force_r = vecs[v].r;
      rdy_pct = (v % 2) ? 50 : 100;
      s0 = n_step;
      frame(vecs[v].n, vecs[v].s, 1'b0, -1, 1'b1, vecs[v].i, vecs[v].q);
      drain();
      mism = 0; eofpos = -1;
      foreach (got_q[j]) begin
        if (j >= 90 && (got_q[j].i != vecs[v].ei || got_q[j].q != vecs[v].eq)) mism++;
        if (j < 90 && (got_q[j].i != vecs[v].i || got_q[j].q != vecs[v].q)) mism++;
        if (got_q[j].eof && eofpos < 0) eofpos = j;
      end
      chk($sformatf("vec%0d_value_mismatches", v), mism, 0);
      chk($sformatf("vec%0d_eof_pos", v), eofpos, 90 + 90 * vecs[v].s - 1);
      chk($sformatf("vec%0d_steps", v), n_step - s0, vecs[v].n + 90 * vecs[v].s);
      compare($sformatf("vec%0d", v));
    end
    force_en = 1'b0;

    // n=5 header-only frame, downstream ready half the time.
    rdy_pct = 50; vld_pct = 100;
    r0 = n_rst; s0 = n_step; step_first = -1;
    frame(5, 0, 1'b0, -1, 1'b0, 0, 0);
    drain();
    chk("seed5_resets", n_rst - r0, 1);
    chk("seed5_steps", n_step - s0, 5);
    chk("seed5_first_step", step_first - rst_cyc, 1);
    chk("seed5_last_step", step_last - rst_cyc, 5);
    compare("hdr_only");

    // n=200 at full rate: payload cannot start before seeding has finished.
    rdy_pct = 100; vld_pct = 100;
    frame(200, 1, 1'b0, -1, 1'b0, 0, 0);
    chk("seed200_first_payload", pay0_cyc - rst_cyc, 201);
    drain();
    compare("seed200");

    // sof at payload symbol 40 aborts the frame without an eof.
    rdy_pct = 70; vld_pct = 80;
    e0 = n_err; r0 = n_rst;
    frame(2, 1, 1'b0, 130, 1'b0, 0, 0);
    frame(3, 0, 1'b0, -1, 1'b0, 0, 0);
    drain();
    chk("abort_err_pulses", n_err - e0, 1);
    chk("abort_resets", n_rst - r0, 2);
    compare("abort");

    // Random frames with stray non-sof symbols between them.
    for (int f = 0; f < 6; f++) begin
      rdy_pct = 40 + 10 * f; vld_pct = 90 - 8 * f;
      e0 = n_err;
      junk = $urandom_range(2);
      for (int j = 0; j < junk; j++) send(int'($urandom), int'($urandom), 1'b0);
      frame($urandom_range(300), $urandom_range(2), 1'($urandom), -1, 1'b0, 0, 0);
      drain();
      chk($sformatf("rand%0d_err_pulses", f), n_err - e0, junk);
      compare($sformatf("rand%0d", f));
    end

    // S=33 with pilots requested.
    rdy_pct = 100; vld_pct = 100;
    frame(7, 33, 1'b1, -1, 1'b0, 0, 0);
    drain();
    chk("s33_frame_len", got_q.size(), PIL_EN ? 3132 : 3060);
    compare("s33");

    // reset in the middle of a header clears everything on the next cycle.
    frame(4, 2, 1'b0, 30, 1'b0, 0, 0);
    reset = 1'b1; s_valid = 1'b1; s_sof = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_all_zero("midreset");
    @(posedge clk); #1;
    reset = 1'b0; s_valid = 1'b0; s_sof = 1'b0;
    got_q.delete(); exp_q.delete();
    step(a);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_m_valid", m_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
